// File: rtl/out_channel_check.sv
// Buffers VM out-instruction words in a small ring and compares them with an expected-value stream.
// Optional macro OUT_CHANNEL_OVERWRITE_EN: a full buffer drops its oldest word instead of back-pressuring.
module out_channel_check #(
    parameter int MemoryElementWidth = 12,
    parameter int NOut               = 2
) (
    input  logic                    clock,
    input  logic                    run,
    input  logic                    out_valid,
    input  logic [MemoryElementWidth-1:0] out_data,
    output logic                    out_ready,
    input  logic                    vm_finished,
    input  logic                    exp_valid,
    input  logic [MemoryElementWidth-1:0] exp_data,
    output logic                    exp_ready,
    input  logic [15:0]             exp_total,
    output logic                    finished,
    output logic                    success,
    output logic [15:0]             checked,
    output logic [15:0]             mismatches,
    output logic [15:0]             first_bad,
    output logic [15:0]             dropped,
    output logic [1:0]              state_dbg,
    output logic [$clog2(NOut):0]   occupancy_dbg
);

    localparam int PW = $clog2(NOut);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(NOut);
    localparam logic [15:0] NONE = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [MemoryElementWidth-1:0] mem_q [NOut];
    logic [PW-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                 occ_q, occ_d;
    logic [15:0]                   checked_q, checked_d, mismatches_q, mismatches_d;
    logic [15:0]                   first_bad_q, first_bad_d, dropped_q, dropped_d;
    logic                          finished_q, finished_d, success_q, success_d;
    logic                          running, push, pop, overwrite, mismatch;
    logic [MemoryElementWidth-1:0] head;

    // Both channels use valid/ready: a transfer completes at a rising edge where valid and
    // ready are both high; ready is combinational and forced low in reset and in DONE.
    always_comb begin
        head      = mem_q[rd_ptr_q];
        running   = run && (state_q != ST_DONE);
        exp_ready = running && (occ_q != '0);
        pop       = exp_valid && exp_ready;
`ifdef OUT_CHANNEL_OVERWRITE_EN
        out_ready = running;
        push      = out_valid && out_ready;
        overwrite = push && !pop && (occ_q == FULL);
`else
        out_ready = running && ((occ_q < FULL) || pop);
        push      = out_valid && out_ready;
        overwrite = 1'b0;
`endif
        mismatch  = pop && (head != exp_data);
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        checked_d    = checked_q;
        mismatches_d = mismatches_q;
        first_bad_d  = first_bad_q;
        dropped_d    = dropped_q;
        state_d      = state_q;
        finished_d   = finished_q;
        success_d    = success_q;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        // An overwrite discards the oldest word, so the read side moves with it.
        if (pop || overwrite) rd_ptr_d = rd_ptr_q + PW'(1);

        case ({push && !overwrite, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase

        if (pop && checked_q != NONE) checked_d = checked_q + 16'd1;
        if (mismatch && mismatches_q != NONE) mismatches_d = mismatches_q + 16'd1;
        if (mismatch && first_bad_q == NONE) first_bad_d = checked_q;
        if (overwrite && dropped_q != NONE) dropped_d = dropped_q + 16'd1;

        case (state_q)
            ST_RUN: begin
                if (vm_finished) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (occ_q == '0 && !push) begin
                    state_d    = ST_DONE;
                    finished_d = 1'b1;
                    success_d  = (mismatches_d == 16'd0) && (checked_d == exp_total) &&
                                 (dropped_d == 16'd0);
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!run) begin
            state_q      <= ST_RUN;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            checked_q    <= '0;
            mismatches_q <= '0;
            first_bad_q  <= NONE;
            dropped_q    <= '0;
            finished_q   <= 1'b0;
            success_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            checked_q    <= checked_d;
            mismatches_q <= mismatches_d;
            first_bad_q  <= first_bad_d;
            dropped_q    <= dropped_d;
            finished_q   <= finished_d;
            success_q    <= success_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are meaningful.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= out_data;
    end

    assign finished      = finished_q;
    assign success       = success_q;
    assign checked       = checked_q;
    assign mismatches    = mismatches_q;
    assign first_bad     = first_bad_q;
    assign dropped       = dropped_q;
    assign state_dbg     = state_q;
    assign occupancy_dbg = occ_q;

endmodule
